data_sync: RTL and testbench

Multi-bit clock-domain-crossing stage that sits directly downstream of the bit synchronizer. It carries a data bus plus a single-bit valid level from a source clock domain into the CLK domain. Only the enable level passes through an internal NUM_STAGES-deep flop chain, built the same way as the bit synchronizer. A rising edge at the chain output produces a one-cycle ENABLE_PULSE, and the bus is captured into SYNC_BUS on that same edge, so the bus itself never needs per-bit synchronization.

---
 rtl/data_sync.sv | 54 +++++
 tb/tb_data_sync.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_sync.sv
// Multi-bit CDC stage: the enable level crosses through a flop chain; its
// synchronized rising edge strobes a one-cycle pulse and captures the bus.
module data_sync #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  logic [NUM_STAGES-1:0] sync_en;
  logic                  en_q;
  logic                  pulse_gen;

  // Enable synchronizer chain; sync_en[0] is the metastability-exposed flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_en <= '0;
    end else begin
      sync_en <= {sync_en[NUM_STAGES-2:0], bus_enable};
    end
  end

  // Delayed copy of the chain output for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= sync_en[NUM_STAGES-1];
    end
  end

  always_comb begin
    pulse_gen = sync_en[NUM_STAGES-1] & ~en_q;
  end

  // Pulse and bus capture share the same edge so the consumer sees both together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_pulse <= 1'b0;
      sync_bus     <= '0;
    end else begin
      enable_pulse <= pulse_gen;
      if (pulse_gen) begin
        sync_bus <= unsync_bus;
      end
    end
  end

endmodule

// File: tb/tb_data_sync.sv
// Directed bench for data_sync: default 8-bit/2-stage instance and a
// 16-bit/3-stage instance driven from the same clock.
module tb_data_sync;

  logic        clk = 1'b0;
  logic        run = 1'b0;

  logic        rst_a;
  logic [7:0]  bus_a;
  logic        en_a;
  logic [7:0]  sbus_a;
  logic        pulse_a;

  logic        rst_b;
  logic [15:0] bus_b;
  logic        en_b;
  logic [15:0] sbus_b;
  logic        pulse_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = run ? ~clk : clk;

  data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2)) u_a (
    .clk          (clk),
    .rst          (rst_a),
    .unsync_bus   (bus_a),
    .bus_enable   (en_a),
    .sync_bus     (sbus_a),
    .enable_pulse (pulse_a)
  );

  data_sync #(.BUS_WIDTH(16), .NUM_STAGES(3)) u_b (
    .clk          (clk),
    .rst          (rst_b),
    .unsync_bus   (bus_b),
    .bus_enable   (en_b),
    .sync_bus     (sbus_b),
    .enable_pulse (pulse_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic p, input logic [7:0] b);
    chk({tag, ".pulse"}, 16'(pulse_a), 16'(p));
    chk({tag, ".bus"}, 16'(sbus_a), 16'(b));
  endtask

  task automatic chk_b(input string tag, input logic p, input logic [15:0] b);
    chk({tag, ".pulse"}, 16'(pulse_b), 16'(p));
    chk({tag, ".bus"}, sbus_b, b);
  endtask

  // Full compliant transfer on the 2-stage instance: enable high 6 edges, low 4.
  task automatic xfer_a(input string tag, input logic [7:0] data, input logic [7:0] prev);
    bus_a = data;
    tick();
    en_a = 1'b1;
    tick(); chk_a({tag, ".e0"}, 1'b0, prev);
    tick(); chk_a({tag, ".e1"}, 1'b0, prev);
    tick(); chk_a({tag, ".e2"}, 1'b1, data);
    tick(); chk_a({tag, ".e3"}, 1'b0, data);
    tick(); chk_a({tag, ".e4"}, 1'b0, data);
    tick(); chk_a({tag, ".e5"}, 1'b0, data);
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a({tag, ".low"}, 1'b0, data);
    end
  endtask

  initial begin
    rst_a = 1'b0; bus_a = 8'hA5; en_a = 1'b1;
    rst_b = 1'b0; bus_b = 16'h0000; en_b = 1'b0;
    #1;
    chk_a("rst_noclk", 1'b0, 8'h00);
    chk_b("rst_noclk_b", 1'b0, 16'h0000);

    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_a("rst_held", 1'b0, 8'h00);
    end

    en_a = 1'b0; bus_a = 8'h00;
    tick();
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_a("post_rst", 1'b0, 8'h00);
    end

    xfer_a("single", 8'h3C, 8'h00);
    xfer_a("two_1", 8'h11, 8'h3C);
    xfer_a("two_2", 8'hEE, 8'h11);

    bus_a = 8'h00; tick(); chk_a("busidle_00", 1'b0, 8'hEE);
    bus_a = 8'hFF; tick(); chk_a("busidle_ff", 1'b0, 8'hEE);
    bus_a = 8'h55; tick(); chk_a("busidle_55", 1'b0, 8'hEE);
    tick(); chk_a("busidle_end", 1'b0, 8'hEE);

    // Reset lands after E0+1, so the pulse due at E0+2 must never appear.
    bus_a = 8'h77;
    tick();
    en_a = 1'b1;
    tick(); chk_a("midrst.e0", 1'b0, 8'hEE);
    tick(); chk_a("midrst.e1", 1'b0, 8'hEE);
    rst_a = 1'b0;
    #1; chk_a("midrst.async", 1'b0, 8'h00);
    tick(); chk_a("midrst.old_e2", 1'b0, 8'h00);
    rst_a = 1'b1;
    tick(); chk_a("midrst.r0", 1'b0, 8'h00);
    tick(); chk_a("midrst.r1", 1'b0, 8'h00);
    tick(); chk_a("midrst.r2", 1'b1, 8'h77);
    tick(); chk_a("midrst.r3", 1'b0, 8'h77);
    tick(); chk_a("midrst.r4", 1'b0, 8'h77);
    en_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_a("midrst.low", 1'b0, 8'h77);
    end

    // Three-stage instance: pulse and capture at E0+3.
    bus_b = 16'hBEEF;
    tick();
    en_b = 1'b1;
    tick(); chk_b("deep.e0", 1'b0, 16'h0000);
    tick(); chk_b("deep.e1", 1'b0, 16'h0000);
    tick(); chk_b("deep.e2", 1'b0, 16'h0000);
    tick(); chk_b("deep.e3", 1'b1, 16'hBEEF);
    tick(); chk_b("deep.e4", 1'b0, 16'hBEEF);
    tick(); chk_b("deep.e5", 1'b0, 16'hBEEF);
    tick(); chk_b("deep.e6", 1'b0, 16'hBEEF);
    en_b = 1'b0;
    bus_b = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_b("deep.low", 1'b0, 16'hBEEF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
